// File: rtl/pc_flow_ctrl.sv
// pc_flow_ctrl: drives the PC update interface from branch, stall, call,
// interrupt and soft-restart requests. An interrupt entry saves the return
// PC as two stack pushes (low half first), then vectors to address 0.
// Every output is registered, so it shows the decision taken on the
// previous rising edge.
//
// state          | meaning
// ---------------+--------------------------------------------------------
// S_IDLE         | normal flow: branch / stall / +1, may start call or int
// S_CALL_E       | CALL is in execute: load the call target
// S_INT_PUSH_LO  | push savedPc low half, hold PC
// S_INT_PUSH_HI  | push savedPc high half, hold PC
// S_INT_VEC      | vector to 0 and acknowledge the interrupt
//
// PC_W must be exactly 2*DATA_W: the return PC is split into two equal
// halves for the stack.

module pc_flow_ctrl #(
  parameter int PC_W   = 32,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [PC_W-1:0]   pcIn,
  input  logic              branchTaken,
  input  logic              stallReq,
  input  logic              callDecoded,
  input  logic              intReq,
  input  logic              restartReq,
  output logic [1:0]        pcSrc,
  output logic [1:0]        interruptSignal,
  output logic [1:0]        firstTimeCallAfterD2E,
  output logic              stackPush,
  output logic [DATA_W-1:0] stackData,
  output logic              flushPipe,
  output logic              intAck
);

  localparam logic [1:0] PC_INC  = 2'b00;
  localparam logic [1:0] PC_BR   = 2'b01;
  localparam logic [1:0] PC_HOLD = 2'b10;
  localparam logic [1:0] INT_VEC = 2'b11;
  localparam logic [1:0] INT_RST = 2'b01;
  localparam logic [1:0] CALL_LD = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CALL_E,
    S_INT_PUSH_LO,
    S_INT_PUSH_HI,
    S_INT_VEC
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_int_pending;
  logic              w_int_pending_nxt;
  logic [PC_W-1:0]   r_saved_pc;
  logic [PC_W-1:0]   w_saved_pc_nxt;

  logic [1:0]        w_pc_src;
  logic [1:0]        w_int_sig;
  logic [1:0]        w_call_ld;
  logic              w_push;
  logic [DATA_W-1:0] w_push_data;
  logic              w_flush;
  logic              w_int_ack;

  // State, pending flag, saved PC and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state               <= S_IDLE;
      r_int_pending         <= 1'b0;
      r_saved_pc            <= '0;
      pcSrc                 <= PC_INC;
      interruptSignal       <= 2'b00;
      firstTimeCallAfterD2E <= 2'b00;
      stackPush             <= 1'b0;
      stackData             <= '0;
      flushPipe             <= 1'b0;
      intAck                <= 1'b0;
    end else begin
      r_state               <= w_state_nxt;
      r_int_pending         <= w_int_pending_nxt;
      r_saved_pc            <= w_saved_pc_nxt;
      pcSrc                 <= w_pc_src;
      interruptSignal       <= w_int_sig;
      firstTimeCallAfterD2E <= w_call_ld;
      stackPush             <= w_push;
      stackData             <= w_push_data;
      flushPipe             <= w_flush;
      intAck                <= w_int_ack;
    end
  end

  // Prioritised next-state and next-output decision
  always_comb begin
    w_state_nxt       = r_state;
    w_int_pending_nxt = r_int_pending;
    w_saved_pc_nxt    = r_saved_pc;
    w_pc_src          = PC_INC;
    w_int_sig         = 2'b00;
    w_call_ld         = 2'b00;
    w_push            = 1'b0;
    w_push_data       = '0;
    w_flush           = 1'b0;
    w_int_ack         = 1'b0;

    if (restartReq) begin
      // abandons any interrupt sequence; no further pushes
      w_state_nxt       = S_IDLE;
      w_int_pending_nxt = 1'b0;
      w_int_sig         = INT_RST;
      w_flush           = 1'b1;
    end else begin
      case (r_state)
        S_INT_PUSH_LO: begin
          w_push      = 1'b1;
          w_push_data = r_saved_pc[DATA_W-1:0];
          w_pc_src    = PC_HOLD;
          w_flush     = 1'b1;
          w_state_nxt = S_INT_PUSH_HI;
        end
        S_INT_PUSH_HI: begin
          w_push            = 1'b1;
          w_push_data       = r_saved_pc[PC_W-1:DATA_W];
          w_pc_src          = PC_HOLD;
          w_flush           = 1'b1;
          w_state_nxt       = S_INT_VEC;
          w_int_pending_nxt = 1'b0;
        end
        S_INT_VEC: begin
          w_int_sig   = INT_VEC;
          w_int_ack   = 1'b1;
          w_flush     = 1'b1;
          w_state_nxt = S_IDLE;
        end
        S_CALL_E: begin
          // stall is deliberately ignored while the call target loads
          w_call_ld         = CALL_LD;
          w_flush           = 1'b1;
          w_state_nxt       = S_IDLE;
          w_int_pending_nxt = r_int_pending | intReq;
        end
        default: begin
          if (r_int_pending && !stallReq && !callDecoded) begin
            // a same-edge branch is dropped; it re-executes after return
            w_saved_pc_nxt = pcIn;
            w_pc_src       = PC_HOLD;
            w_state_nxt    = S_INT_PUSH_LO;
          end else begin
            w_int_pending_nxt = r_int_pending | intReq;
            if (callDecoded) begin
              w_pc_src    = PC_HOLD;
              w_state_nxt = S_CALL_E;
            end else if (branchTaken) begin
              w_pc_src = PC_BR;
              w_flush  = 1'b1;
            end else if (stallReq) begin
              w_pc_src = PC_HOLD;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: doc/pc_flow_ctrl.md
Name: pc_flow_ctrl

Overview:
- Control-side initiator that drives the program-counter update interface: per-cycle pcSrc, interruptSignal and firstTimeCallAfterD2E codes.
- Arbitrates branch, stall, call, external interrupt and soft-restart requests from decode/execute and the interrupt pin.
- Sequences the interrupt entry: saves the 32-bit return PC to the stack over the 16-bit data path in two pushes, then vectors to address 0.
- Sits between hazard/branch logic and the PC register; all outputs are registered.

Parameters:
- PC_W, 32, program-counter width.
- DATA_W, 16, stack data-path width; PC_W must equal 2*DATA_W.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset; 0 asserts.
- pcIn  input  PC_W  current PC value, the return address candidate.
- branchTaken  input  1  execute stage resolved a taken branch this cycle.
- stallReq  input  1  hazard unit requests that fetch be held.
- callDecoded  input  1  CALL instruction is moving D→E this cycle.
- intReq  input  1  external interrupt request, level or pulse.
- restartReq  input  1  soft restart request, pulse.
- pcSrc  output  2  00 = +1, 01 = branch target, 10 = -1 (hold).
- interruptSignal  output  2  00 = none, 11 = vector to 0, 01 = restart.
- firstTimeCallAfterD2E  output  2  11 = load call target, otherwise 00.
- stackPush  output  1  push stackData this cycle.
- stackData  output  DATA_W  word being pushed.
- flushPipe  output  1  squash fetch/decode.
- intAck  output  1  one-cycle acknowledge at vector time.

Behaviour:
- Reset (reset=0, asynchronous):
  - State = IDLE.
  - intPending = 0, savedPc = 0.
  - All outputs 0, so pcSrc = 00 and interruptSignal = 00.
- Outputs are registered. Each output reflects the decision made from the inputs on the previous rising edge (latency 1).
- intPending is set on any clk edge with intReq = 1. It is cleared when INT_VEC is entered. A new intReq during the sequence is ignored.
- States: IDLE, CALL_E, INT_PUSH_LO, INT_PUSH_HI, INT_VEC.
- Decision priority, evaluated each edge:
  1. restartReq = 1 from any state:
     - Drive interruptSignal = 01 and flushPipe = 1 for one cycle.
     - Go to IDLE and clear intPending.
     - An interrupt sequence in progress is abandoned with no further pushes.
  2. State INT_PUSH_LO:
     - stackPush = 1, stackData = savedPc[15:0], pcSrc = 10, flushPipe = 1.
     - Next state INT_PUSH_HI.
  3. State INT_PUSH_HI:
     - stackPush = 1, stackData = savedPc[31:16], pcSrc = 10, flushPipe = 1.
     - Next state INT_VEC.
  4. State INT_VEC:
     - interruptSignal = 11, intAck = 1, flushPipe = 1.
     - Next state IDLE.
  5. State CALL_E:
     - firstTimeCallAfterD2E = 11, flushPipe = 1.
     - Next state IDLE.
     - stallReq is ignored in this cycle.
  6. IDLE with intPending = 1, stallReq = 0 and callDecoded = 0:
     - Capture savedPc = pcIn, go to INT_PUSH_LO.
     - pcSrc = 10 (hold) for this cycle.
     - A branchTaken on the same edge: savedPc = pcIn is still captured, and the branch is dropped and re-executed after return.
  7. IDLE, callDecoded = 1:
     - Go to CALL_E.
     - pcSrc = 10 this cycle, so the PC does not advance past the call.
     - A pending interrupt waits until IDLE is re-entered.
  8. IDLE, branchTaken = 1: pcSrc = 01, flushPipe = 1.
  9. IDLE, stallReq = 1: pcSrc = 10.
  10. Otherwise: pcSrc = 00.
- Mutual exclusion invariant:
  - At most one of pcSrc ≠ 00, interruptSignal ≠ 00, firstTimeCallAfterD2E ≠ 00 is active per cycle.
  - Exception: pcSrc = 10 is allowed together with stackPush.
- Interrupt deferral: deferred indefinitely while stallReq = 1 or callDecoded = 1. No timeout.
- Reset mid-sequence: all state cleared; no partial push is completed.
- stackData = 0 whenever stackPush = 0.

Test Plan:
- Reset and idle: hold reset = 0 for 2 cycles, release; drive no requests for 5 cycles → all outputs 00/0 throughout.
- Branch vs stall: at cycle 3 drive branchTaken = 1 and stallReq = 1 together → cycle 4 pcSrc = 01 and flushPipe = 1; at cycle 5 drive stallReq only → cycle 6 pcSrc = 10.
- Interrupt entry: drive pcIn = 32'h0001_2345 and pulse intReq with no stall. Required sequence:
  - hold edge: pcSrc = 10;
  - next cycle: stackPush = 1, stackData = 16'h2345;
  - next: stackPush = 1, stackData = 16'h0001;
  - next: interruptSignal = 11, intAck = 1;
  - then back to IDLE with pcSrc = 00.
- Interrupt deferred by call: pulse intReq on the same cycle as callDecoded = 1. Required sequence:
  - pcSrc = 10;
  - next cycle firstTimeCallAfterD2E = 11;
  - then the interrupt sequence starts with savedPc = pcIn sampled after CALL_E.
- Stall deferral: hold stallReq = 1 for 6 cycles with intReq pulsed at cycle 1 → pcSrc = 10 for each stalled cycle; the push sequence begins on the first edge after stallReq falls.
- Restart mid-sequence and async reset:
  - Pulse restartReq during INT_PUSH_HI → next cycle interruptSignal = 01, stackPush = 0, then IDLE.
  - Separately assert reset = 0 between clock edges during INT_PUSH_LO → outputs clear to 0 immediately, with no clock edge needed.
